matrix_output_deskew: RTL and testbench
=======================================

Name: matrix_output_deskew

Overview:
- Receives the diagonally skewed result wavefront from the systolic array. Lane k arrives k cycles after lane 0.
- Re-aligns all lanes into one full-width row vector per wavefront.
- Buffers aligned rows in a single FIFO and hands them to the writeback path over a valid/ready handshake.
- Inverse of the staggered per-row read scheme used on the array input side.

Parameters:
- DEPTH, 8, number of lanes (array rows); skew spans DEPTH-1 cycles.
- WIDTH, 8, bits per lane element.
- ADDRESS_WIDTH, 3, FIFO address bits; FIFO_DEPTH = 2^ADDRESS_WIDTH rows.

Ports:
- CLK  input  1  sole clock, rising edge.
- RESET  input  1  synchronous, active-high reset.
- Data_in  input  DEPTH*WIDTH  skewed lane data; lane k = bits [k*WIDTH +: WIDTH].
- valid  input  1  marks lane 0 of a new wavefront at this edge.
- Data_out  output  DEPTH*WIDTH  aligned row at FIFO head (first-word fall-through).
- Out_valid  output  1  FIFO non-empty.
- Out_ready  input  1  consumer accepts head row when Out_valid=1.
- Count_out  output  ADDRESS_WIDTH+1  rows currently stored.
- Almost_full_out  output  1  Count_out > FIFO_DEPTH-DEPTH; upstream must stop launching wavefronts.
- Overflow_out  output  1  sticky; a row was dropped.

Behaviour:
- Skew convention: if valid=1 at edge t, lane k data is sampled from Data_in at edge t+k, for k=0..DEPTH-1. Data_in lane k at other edges is ignored.
- Valid tracking: a DEPTH-1 bit shift register records valid history. Lane k's delay line is DEPTH-1-k registers long, so lane k's element aligns at edge t+DEPTH-1. Lane DEPTH-1 is taken directly from Data_in.
- Write: at edge t+DEPTH-1 the assembled row is pushed into the FIFO (wr_en = valid delayed DEPTH-1 cycles).
- Latency: Out_valid rises in the cycle after edge t+DEPTH-1, i.e. DEPTH-1 edges after valid was sampled, provided the FIFO was empty.
- Throughput: back-to-back wavefronts (valid high on consecutive edges) are supported, up to one row per cycle.
- Read: pop occurs when Out_valid && Out_ready at an edge. Data_out shows the next row (or 0) in the following cycle.
- Data_out is 0 whenever Out_valid=0.
- Simultaneous push and pop:
  - Count_out unchanged.
  - Allowed when full; the pop frees the slot and the push succeeds.
  - When empty, the pushed row appears at the head the next cycle; the pop is ignored because Out_valid=0.
- Full (Count_out = FIFO_DEPTH) with push and no pop: the row is dropped, Overflow_out is set and held until RESET, and FIFO contents are unchanged.
- Empty with Out_ready=1: no effect.
- Pointers: wrap modulo FIFO_DEPTH. Full and empty are distinguished by an extra pointer MSB.
- Reset values: Out_valid=0, Data_out=0, Count_out=0, Almost_full_out=0, Overflow_out=0.
- RESET mid-operation:
  - Clears the valid shift register, pointers and overflow flag.
  - Any partially assembled wavefront is discarded, and no write occurs from it after RESET deasserts.
  - Delay-line data registers need not be reset.
- Almost_full_out is combinational from Count_out.

Test Plan:
- DEPTH=4, WIDTH=8, ADDRESS_WIDTH=3. Single wavefront: valid=1 at edge 0; lanes 0..3 = 0x11,0x22,0x33,0x44 at edges 0..3 -> Out_valid rises after edge 3; Data_out = 0x44332211; Count_out=1. Out_ready=1 one cycle -> Out_valid=0, Data_out=0.
- Back-to-back: valid on edges 0..2 with distinct rows, Out_ready=0 -> three aligned rows in order after edges 3,4,5; Count_out=3; drain returns them in order.
- Fill: 8 wavefronts, Out_ready=0 -> Count_out=8; Almost_full_out=1 from Count_out=5. 9th wavefront -> dropped, Overflow_out=1, Count_out stays 8, head unchanged.
- Full with simultaneous pop: Count_out=8, Out_ready=1 on the 9th row's push edge -> row accepted, Count_out=8, Overflow_out stays 0.
- Pointer wrap: 20 rows streamed with Out_ready=1 continuously -> all 20 emitted in order, Count_out ≤1, no overflow.
- Reset mid-wavefront: valid at edge 0, RESET=1 at edge 2 -> no row written after reset; all outputs 0; a subsequent clean wavefront is emitted correctly.

Source files
------------

// File: rtl/matrix_output_deskew.sv
// Realigns the diagonally skewed systolic-array result wavefront into full rows
// and queues them in a first-word-fall-through FIFO toward writeback.
module matrix_output_deskew #(
  parameter int DEPTH         = 8,
  parameter int WIDTH         = 8,
  parameter int ADDRESS_WIDTH = 3
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [DEPTH*WIDTH-1:0]   Data_in,
  input  logic                     valid,
  output logic [DEPTH*WIDTH-1:0]   Data_out,
  output logic                     Out_valid,
  input  logic                     Out_ready,
  output logic [ADDRESS_WIDTH:0]   Count_out,
  output logic                     Almost_full_out,
  output logic                     Overflow_out
);

  localparam int RW         = DEPTH * WIDTH;
  localparam int FIFO_DEPTH = 1 << ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH:0] FULL_LEVEL = (ADDRESS_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [ADDRESS_WIDTH:0] AF_LEVEL   = (ADDRESS_WIDTH+1)'(FIFO_DEPTH - DEPTH);
  localparam logic [ADDRESS_WIDTH:0] PTR_ONE    = (ADDRESS_WIDTH+1)'(1);

  logic [DEPTH-2:0]       valid_sr;
  logic [RW-1:0]          row;
  logic [RW-1:0]          mem [FIFO_DEPTH];
  logic [ADDRESS_WIDTH:0] wr_ptr;
  logic [ADDRESS_WIDTH:0] rd_ptr;
  logic                   wr_en;
  logic                   full;
  logic                   pop;
  logic                   push;

  // Valid history: bit i is valid delayed i+1 edges; the oldest bit marks row completion.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_sr <= '0;
    end else begin
      valid_sr[0] <= valid;
      for (int i = 1; i < DEPTH-1; i++) valid_sr[i] <= valid_sr[i-1];
    end
  end

  // Lane k waits DEPTH-1-k edges so every lane lands on the same edge as lane DEPTH-1.
  for (genvar k = 0; k < DEPTH-1; k++) begin : g_lane
    localparam int LEN = DEPTH - 1 - k;
    logic [WIDTH-1:0] dly [LEN];
    always_ff @(posedge CLK) begin
      dly[0] <= Data_in[k*WIDTH +: WIDTH];
      for (int j = 1; j < LEN; j++) dly[j] <= dly[j-1];
    end
    assign row[k*WIDTH +: WIDTH] = dly[LEN-1];
  end
  assign row[(DEPTH-1)*WIDTH +: WIDTH] = Data_in[(DEPTH-1)*WIDTH +: WIDTH];

  // Handshake: the head row transfers on any edge where Out_valid && Out_ready are both
  // high; Out_valid never depends on Out_ready, and Data_out is zero while Out_valid is low.
  assign wr_en           = valid_sr[DEPTH-2];
  assign Count_out       = wr_ptr - rd_ptr;
  assign Out_valid       = (Count_out != '0);
  assign full            = (Count_out == FULL_LEVEL);
  assign pop             = Out_valid && Out_ready;
  assign push            = wr_en && (!full || pop);
  assign Data_out        = Out_valid ? mem[rd_ptr[ADDRESS_WIDTH-1:0]] : '0;
  assign Almost_full_out = (Count_out > AF_LEVEL);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      Overflow_out <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (wr_en && full && !pop) Overflow_out <= 1'b1;
    end
  end

  // Storage needs no reset; a full FIFO being popped frees the slot written here.
  always_ff @(posedge CLK) begin
    if (!RESET && push) mem[wr_ptr[ADDRESS_WIDTH-1:0]] <= row;
  end

endmodule

// File: tb/tb_matrix_output_deskew.sv
// Bench for matrix_output_deskew: directed scenarios plus random traffic, checked every
// cycle against a queue model that rebuilds rows from the recorded input history.
module tb_matrix_output_deskew;

  localparam int DEPTH = 4;
  localparam int WIDTH = 8;
  localparam int AW    = 3;
  localparam int DW    = DEPTH * WIDTH;
  localparam int FD    = 1 << AW;
  localparam int MAXC  = 4095;

  logic          CLK;
  logic          RESET;
  logic [DW-1:0] Data_in;
  logic          valid;
  logic [DW-1:0] Data_out;
  logic          Out_valid;
  logic          Out_ready;
  logic [AW:0]   Count_out;
  logic          Almost_full_out;
  logic          Overflow_out;

  matrix_output_deskew #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDRESS_WIDTH(AW)) dut (
    .CLK(CLK), .RESET(RESET), .Data_in(Data_in), .valid(valid),
    .Data_out(Data_out), .Out_valid(Out_valid), .Out_ready(Out_ready),
    .Count_out(Count_out), .Almost_full_out(Almost_full_out), .Overflow_out(Overflow_out)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // behavioural model: input history plus a queue of rows in FIFO order
  logic [DW-1:0] hd [0:MAXC];
  logic          hv [0:MAXC];
  logic          hr [0:MAXC];
  logic [DW-1:0] exp_q[$];
  logic          m_ovf = 1'b0;
  logic          seen_reset = 1'b0;
  int            cyc_n = 0;

  initial begin
    for (int i = 0; i <= MAXC; i++) begin
      hd[i] = '0; hv[i] = 1'b0; hr[i] = 1'b1;
    end
  end

  always @(posedge CLK) begin
    logic          m_pop;
    logic          m_push;
    logic [DW-1:0] r;
    int            e;
    cyc_n++;
    hd[cyc_n] = Data_in;
    hv[cyc_n] = valid;
    hr[cyc_n] = RESET;
    if (RESET) begin
      seen_reset = 1'b1;
      exp_q.delete();
      m_ovf = 1'b0;
    end else begin
      m_pop  = (exp_q.size() > 0) && Out_ready;
      m_push = 1'b0;
      r      = '0;
      if (cyc_n > DEPTH-1) begin
        e = cyc_n - (DEPTH-1);
        m_push = hv[e];
        for (int j = e; j <= cyc_n; j++) if (hr[j]) m_push = 1'b0;
        for (int k = 0; k < DEPTH; k++) r[k*WIDTH +: WIDTH] = hd[e+k][k*WIDTH +: WIDTH];
      end
      if (m_pop) void'(exp_q.pop_front());
      if (m_push) begin
        if (exp_q.size() < FD) exp_q.push_back(r);
        else m_ovf = 1'b1;
      end
    end
  end

  // scoreboard compare, away from the active edge
  always @(negedge CLK) begin
    if (seen_reset) begin
      chk("out_valid", {63'd0, Out_valid}, {63'd0, exp_q.size() > 0});
      chk("data_out", {32'd0, Data_out}, (exp_q.size() > 0) ? {32'd0, exp_q[0]} : 64'd0);
      chk("count_out", {60'd0, Count_out}, 64'(exp_q.size()));
      chk("almost_full", {63'd0, Almost_full_out}, {63'd0, exp_q.size() > FD-DEPTH});
      chk("overflow", {63'd0, Overflow_out}, {63'd0, m_ovf});
    end
  end

  // driver tasks
  task automatic drive(input logic v, input logic rdy, input logic rst, input logic [DW-1:0] d);
    @(negedge CLK);
    valid = v; Out_ready = rdy; RESET = rst; Data_in = d;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) drive(1'b0, rdy, 1'b0, DW'($urandom));
  endtask

  task automatic launch(input int n, input logic rdy);
    for (int i = 0; i < n; i++) drive(1'b1, rdy, 1'b0, DW'($urandom));
  endtask

  initial begin
    valid = 1'b0; Out_ready = 1'b0; RESET = 1'b1; Data_in = '0;
    drive(1'b0, 1'b0, 1'b1, '0);
    drive(1'b0, 1'b0, 1'b1, '0);
    drive(1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, 1'b0, '0);
    chk("rst_valid", {63'd0, Out_valid}, 64'd0);
    chk("rst_data", {32'd0, Data_out}, 64'd0);
    chk("rst_count", {60'd0, Count_out}, 64'd0);
    chk("rst_af", {63'd0, Almost_full_out}, 64'd0);
    chk("rst_ovf", {63'd0, Overflow_out}, 64'd0);

    // single wavefront with hand-computed row
    drive(1'b1, 1'b0, 1'b0, 32'h0000_0011);
    drive(1'b0, 1'b0, 1'b0, 32'h0000_2200);
    drive(1'b0, 1'b0, 1'b0, 32'h0033_0000);
    drive(1'b0, 1'b0, 1'b0, 32'h4400_0000);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    chk("single_valid", {63'd0, Out_valid}, 64'd1);
    chk("single_data", {32'd0, Data_out}, 64'h4433_2211);
    chk("single_count", {60'd0, Count_out}, 64'd1);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    chk("single_pop_valid", {63'd0, Out_valid}, 64'd0);
    chk("single_pop_data", {32'd0, Data_out}, 64'd0);

    // back-to-back
    launch(3, 1'b0);
    idle(4, 1'b0);
    chk("b2b_count", {60'd0, Count_out}, 64'd3);
    idle(5, 1'b1);

    // fill then overflow
    launch(8, 1'b0);
    idle(4, 1'b0);
    chk("fill_count", {60'd0, Count_out}, 64'd8);
    chk("fill_af", {63'd0, Almost_full_out}, 64'd1);
    chk("fill_ovf", {63'd0, Overflow_out}, 64'd0);
    launch(1, 1'b0);
    idle(4, 1'b0);
    chk("ovf_set", {63'd0, Overflow_out}, 64'd1);
    chk("ovf_count", {60'd0, Count_out}, 64'd8);

    // full with simultaneous pop on the push edge
    drive(1'b0, 1'b0, 1'b1, '0);
    drive(1'b0, 1'b0, 1'b0, '0);
    launch(8, 1'b0);
    idle(4, 1'b0);
    launch(1, 1'b0);
    idle(2, 1'b0);
    idle(1, 1'b1);
    idle(1, 1'b0);
    chk("fullpop_count", {60'd0, Count_out}, 64'd8);
    chk("fullpop_ovf", {63'd0, Overflow_out}, 64'd0);
    idle(10, 1'b1);

    // pointer wrap, continuous drain
    for (int i = 0; i < 20 + DEPTH; i++) begin
      drive(i < 20, 1'b1, 1'b0, DW'($urandom));
      chk("wrap_count_le1", {63'd0, Count_out <= 1}, 64'd1);
    end
    idle(3, 1'b1);

    // reset in the middle of a wavefront
    drive(1'b1, 1'b0, 1'b0, DW'($urandom));
    drive(1'b0, 1'b0, 1'b0, DW'($urandom));
    drive(1'b0, 1'b0, 1'b1, DW'($urandom));
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b0, DW'($urandom));
      chk("midrst_valid", {63'd0, Out_valid}, 64'd0);
    end
    launch(1, 1'b0);
    idle(DEPTH, 1'b0);
    chk("midrst_clean_count", {60'd0, Count_out}, 64'd1);
    idle(2, 1'b1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
            ($urandom_range(0, 63) == 0), DW'($urandom));
    end
    idle(12, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
